// File: rtl/factorial_seq_param.sv
// Sequential factorial engine: computes n! with one multiply per clock.
// Saturates to all-ones with ovf set as soon as a partial product leaves F_W bits.
// Assumes N_W >= 2 and N_W <= F_W.
module factorial_seq_param #(
  parameter int N_W = 4,
  parameter int F_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] data1,
  output logic           busy,
  output logic           done,
  output logic [F_W-1:0] fact,
  output logic           ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [F_W-1:0]   acc_q, acc_d;
  logic [N_W-1:0]   cnt_q, cnt_d;
  logic [F_W-1:0]   fact_q, fact_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [2*F_W-1:0] prod;

  // Full double-width product of the accumulator and the zero-extended down-counter.
  assign prod = {{F_W{1'b0}}, acc_q} * {{(2*F_W-N_W){1'b0}}, cnt_q};

  // Next-state and datapath updates; every register holds unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fact_d  = fact_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = data1;
          acc_d   = {{(F_W-1){1'b0}}, 1'b1};
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // cnt <= 1 means no multiplies remain (also covers 0! = 1).
        if (cnt_q[N_W-1:1] == '0) begin
          fact_d  = acc_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (prod[2*F_W-1:F_W] == '0) begin
          acc_d = prod[F_W-1:0];
          cnt_d = cnt_q - N_W'(1);
        end else begin
          // Remaining factors are >= 1, so the result can only grow: finish early.
          fact_d  = '1;
          ovf_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous abort on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      fact_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fact_q  <= fact_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fact = fact_q;
  assign ovf  = ovf_q;

endmodule
